// File: rtl/mips_bus_pkg.sv
// Shared types and defaults for the instruction/data memory bus arbiter.
// Holds the FSM state encoding and the bus direction codes.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

    localparam int DEF_WAIT_CYCLES = 2;
    localparam int DEF_MAX_STREAK  = 4;

endpackage

// File: rtl/bus_arb_pick.sv
// Data-over-fetch priority with a streak counter that hands the bus to a
// pending fetch after MAX_STREAK back-to-back data grants.
module bus_arb_pick
    import mips_bus_pkg::*;
#(
    parameter int MAX_STREAK = DEF_MAX_STREAK
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic grant_i,
    input  logic f_req_i,
    input  logic d_req_i,
    output logic pick_data_o
);

    localparam int SW = $clog2(MAX_STREAK + 1);

    logic [SW-1:0] streak_q, streak_d;
    logic          at_max;

    assign at_max      = (streak_q == SW'(MAX_STREAK));
    assign pick_data_o = d_req_i && !(f_req_i && at_max);

    // Only data grants made while a fetch is waiting count toward starvation.
    always_comb begin
        streak_d = streak_q;
        if (grant_i) begin
            if (pick_data_o && f_req_i) begin
                streak_d = at_max ? streak_q : streak_q + SW'(1);
            end else begin
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between an instruction-fetch port and a data port.
// IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE (ACK pulse) -> IDLE.
module mem_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int MAX_STREAK  = DEF_MAX_STREAK
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              F_REQ,
    input  logic [ADDR_W-1:0] F_ADDR,
    output logic              F_ACK,
    output logic [DATA_W-1:0] F_RDATA,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic              D_ACK,
    output logic [DATA_W-1:0] D_RDATA,
    input  logic [DATA_W-1:0] BUS_READ,
    output logic [ADDR_W-1:0] ADDR,
    output logic              CS,
    output logic              CS_P,
    output logic              WR_RD,
    output logic [DATA_W-1:0] Data_BUS_WRITE,
    output logic              BUSY
);

    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] frdata_q, frdata_d;
    logic [DATA_W-1:0] drdata_q, drdata_d;
    logic              cs_q, cs_d;
    logic              csp_q, csp_d;
    logic              wr_q, wr_d;
    logic              fack_q, fack_d;
    logic              dack_q, dack_d;
    logic              grant;
    logic              pick_data;

    bus_arb_pick #(
        .MAX_STREAK (MAX_STREAK)
    ) u_pick (
        .clk_i       (CLK),
        .rst_ni      (RST),
        .grant_i     (grant),
        .f_req_i     (F_REQ),
        .d_req_i     (D_REQ),
        .pick_data_o (pick_data)
    );

    // The bus registers double as the latched transaction while in ACCESS.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cs_d     = cs_q;
        csp_d    = csp_q;
        wr_d     = wr_q;
        frdata_d = frdata_q;
        drdata_d = drdata_q;
        fack_d   = 1'b0;
        dack_d   = 1'b0;
        grant    = 1'b0;

        case (state_q)
            IDLE: begin
                if (F_REQ || D_REQ) begin
                    grant   = 1'b1;
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    if (pick_data) begin
                        cs_d    = 1'b1;
                        csp_d   = 1'b0;
                        wr_d    = D_WE ? WR : RD;
                        addr_d  = D_ADDR;
                        wdata_d = D_WE ? D_WDATA : '0;
                    end else begin
                        cs_d    = 1'b0;
                        csp_d   = 1'b1;
                        wr_d    = RD;
                        addr_d  = F_ADDR;
                        wdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (cs_q) begin
                        dack_d = 1'b1;
                        if (wr_q == RD) drdata_d = BUS_READ;
                    end else begin
                        fack_d   = 1'b1;
                        frdata_d = BUS_READ;
                    end
                    cs_d    = 1'b0;
                    csp_d   = 1'b0;
                    wr_d    = RD;
                    addr_d  = '0;
                    wdata_d = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cs_q     <= 1'b0;
            csp_q    <= 1'b0;
            wr_q     <= RD;
            frdata_q <= '0;
            drdata_q <= '0;
            fack_q   <= 1'b0;
            dack_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cs_q     <= cs_d;
            csp_q    <= csp_d;
            wr_q     <= wr_d;
            frdata_q <= frdata_d;
            drdata_q <= drdata_d;
            fack_q   <= fack_d;
            dack_q   <= dack_d;
        end
    end

    assign ADDR           = addr_q;
    assign CS             = cs_q;
    assign CS_P           = csp_q;
    assign WR_RD          = wr_q;
    assign Data_BUS_WRITE = wdata_q;
    assign F_ACK          = fack_q;
    assign D_ACK          = dack_q;
    assign F_RDATA        = frdata_q;
    assign D_RDATA        = drdata_q;
    assign BUSY           = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed bench for mem_bus_arbiter against a timeline model:
// each grant fixes its bus window, ACK cycle and next sampling point by cycle offset.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int W  = 2;
    localparam int MS = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          F_REQ = 1'b0;
    logic [AW-1:0] F_ADDR = '0;
    logic          F_ACK;
    logic [DW-1:0] F_RDATA;
    logic          D_REQ = 1'b0;
    logic          D_WE = 1'b0;
    logic [AW-1:0] D_ADDR = '0;
    logic [DW-1:0] D_WDATA = '0;
    logic          D_ACK;
    logic [DW-1:0] D_RDATA;
    logic [DW-1:0] BUS_READ = '0;
    logic [AW-1:0] ADDR;
    logic          CS, CS_P, WR_RD, BUSY;
    logic [DW-1:0] Data_BUS_WRITE;

    mem_bus_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W), .MAX_STREAK(MS)
    ) dut (
        .CLK(CLK), .RST(RST),
        .F_REQ(F_REQ), .F_ADDR(F_ADDR), .F_ACK(F_ACK), .F_RDATA(F_RDATA),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_ACK(D_ACK), .D_RDATA(D_RDATA), .BUS_READ(BUS_READ),
        .ADDR(ADDR), .CS(CS), .CS_P(CS_P), .WR_RD(WR_RD),
        .Data_BUS_WRITE(Data_BUS_WRITE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: one transaction at a time, located on the cycle timeline.
    int            cyc = 0;
    bit            m_busy = 0;
    int            m_t0 = -100;
    bit            m_data, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_frd = '0, m_drd = '0;
    int            m_streak = 0;

    // Called at a negedge after inputs for this cycle are set; checks, steps model, advances one cycle.
    task automatic tick();
        int d;
        bit act, ack, pick_d;
        #1;
        if (!RST) begin
            m_busy = 0; m_streak = 0; m_frd = '0; m_drd = '0;
        end
        d = cyc - m_t0;
        if (m_busy && d >= W + 3) m_busy = 0;
        act = m_busy && d >= 1 && d <= W + 1;
        ack = m_busy && d == W + 2;

        chk("CS",     CS,     act && m_data);
        chk("CS_P",   CS_P,   act && !m_data);
        chk("WR_RD",  WR_RD,  act && m_data && m_we);
        chk("ADDR",   ADDR,   act ? m_addr : '0);
        chk("DBW",    Data_BUS_WRITE, (act && m_data && m_we) ? m_wdata : '0);
        chk("F_ACK",  F_ACK,  ack && !m_data);
        chk("D_ACK",  D_ACK,  ack && m_data);
        chk("BUSY",   BUSY,   act || ack);
        chk("F_RDATA", F_RDATA, m_frd);
        chk("D_RDATA", D_RDATA, m_drd);
        chk("CS_excl", CS && CS_P, 1'b0);

        if (RST) begin
            if (act && d == W + 1 && !(m_data && m_we)) begin
                if (m_data) m_drd = BUS_READ;
                else        m_frd = BUS_READ;
            end
            if (!m_busy && (F_REQ || D_REQ)) begin
                pick_d   = D_REQ && !(F_REQ && m_streak == MS);
                m_streak = (pick_d && F_REQ) ? ((m_streak < MS) ? m_streak + 1 : MS) : 0;
                m_data   = pick_d;
                m_we     = pick_d && D_WE;
                m_addr   = pick_d ? D_ADDR : F_ADDR;
                m_wdata  = D_WDATA;
                m_t0     = cyc;
                m_busy   = 1;
            end
        end
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
    endtask

    task automatic drop_on_ack();
        if (F_ACK) F_REQ = 1'b0;
        if (D_ACK) D_REQ = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drop_on_ack();
            tick();
        end
        drop_on_ack();
    endtask

    initial begin
        int nd, last_f;
        bit seen_f;

        @(negedge CLK);
        tick();
        tick();
        RST = 1'b1;
        tick();

        // Single fetch
        F_REQ = 1'b1; F_ADDR = 32'h0000_0040; BUS_READ = 32'h2001_0FA1;
        run(8);
        chk("fetch_rdata", F_RDATA, 32'h2001_0FA1);

        // Data write
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'h0000_2F0F; D_WDATA = 32'd4000000;
        run(8);
        chk("write_drdata", D_RDATA, '0);

        // Simultaneous requests: data first, then fetch
        F_REQ = 1'b1; F_ADDR = 32'h0000_0100; D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h0000_0200;
        BUS_READ = 32'hCAFE_0001;
        run(14);
        chk("both_drdata", D_RDATA, 32'hCAFE_0001);

        // Starvation: both held, count data grants before the fetch completes
        F_REQ = 1'b1; F_ADDR = 32'h0000_0300; D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h0000_0400;
        nd = 0;
        seen_f = 0;
        for (int i = 0; i < 60 && !seen_f; i++) begin
            tick();
            if (D_ACK) nd++;
            if (F_ACK) seen_f = 1;
        end
        chk("starve_fack", seen_f, 1'b1);
        chk("starve_ndata", nd, 4);
        F_REQ = 1'b0; D_REQ = 1'b0;
        run(6);

        // Reset in the second bus cycle aborts the fetch
        F_REQ = 1'b1; F_ADDR = 32'h0000_0500;
        tick();
        tick();
        RST = 1'b0;
        F_REQ = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        tick();
        chk("post_rst_busy", BUSY, 1'b0);
        F_REQ = 1'b1; F_ADDR = 32'h0000_0600; BUS_READ = 32'h1234_5678;
        run(8);
        chk("post_rst_fetch", F_RDATA, 32'h1234_5678);

        // Continuous fetch stream with a fresh address after each ACK
        F_REQ = 1'b1; F_ADDR = $urandom;
        last_f = -1;
        for (int i = 0; i < 30; i++) begin
            BUS_READ = $urandom;
            tick();
            if (F_ACK) begin
                if (last_f >= 0) chk("fetch_period", cyc - last_f, W + 3);
                last_f = cyc;
                F_ADDR = $urandom;
            end
        end
        F_REQ = 1'b0;
        run(6);

        // Random masters obeying the hold-until-ACK handshake
        for (int i = 0; i < 2000; i++) begin
            if (F_REQ && F_ACK) begin
                if ($urandom_range(1, 0) == 1) F_ADDR = $urandom;
                else F_REQ = 1'b0;
            end else if (!F_REQ && $urandom_range(3, 0) == 0) begin
                F_REQ = 1'b1; F_ADDR = $urandom;
            end
            if (D_REQ && D_ACK) begin
                if ($urandom_range(1, 0) == 1) begin
                    D_WE = $urandom_range(1, 0) == 1; D_ADDR = $urandom; D_WDATA = $urandom;
                end else D_REQ = 1'b0;
            end else if (!D_REQ && $urandom_range(2, 0) == 0) begin
                D_REQ = 1'b1; D_WE = $urandom_range(1, 0) == 1; D_ADDR = $urandom; D_WDATA = $urandom;
            end
            BUS_READ = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
